// File: rtl/lcd_timing_gen.sv
// Pixel-timing generator for an 800x480 parallel-RGB LCD: pixel clock (CLK/2), panel strobes
// and the raw Columna/Fila position counters, all registered in the CLK domain.
module lcd_timing_gen #(
    parameter int BACK_PORCH_X  = 216,
    parameter int BACK_PORCH_Y  = 35,
    parameter int FRONT_PORCH_X = 40,
    parameter int FRONT_PORCH_Y = 10,
    parameter int SCREEN_SIZE_X = 800,
    parameter int SCREEN_SIZE_Y = 480,
    parameter int HSYNC_W       = 1,
    parameter int VSYNC_W       = 1
) (
    input  logic        CLK,
    input  logic        RST_n,
    output logic        NCLK,
    output logic        GREST,
    output logic        HD,
    output logic        VD,
    output logic        DEN,
    output logic [10:0] Columna,
    output logic [9:0]  Fila,
    output logic        FRAME_END
);

    localparam int H_TOTAL = BACK_PORCH_X + SCREEN_SIZE_X + FRONT_PORCH_X;
    localparam int V_TOTAL = BACK_PORCH_Y + SCREEN_SIZE_Y + FRONT_PORCH_Y;

    localparam logic [10:0] COL_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  ROW_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] HS_END   = 11'(HSYNC_W);
    localparam logic [9:0]  VS_END   = 10'(VSYNC_W);
    localparam logic [10:0] DEN_X0   = 11'(BACK_PORCH_X);
    localparam logic [10:0] DEN_X1   = 11'(BACK_PORCH_X + SCREEN_SIZE_X);
    localparam logic [9:0]  DEN_Y0   = 10'(BACK_PORCH_Y);
    localparam logic [9:0]  DEN_Y1   = 10'(BACK_PORCH_Y + SCREEN_SIZE_Y);

    logic        pix_tick;
    logic        col_wrap;
    logic        row_wrap;
    logic [10:0] col_next;
    logic [9:0]  row_next;
    logic        hd_next;
    logic        vd_next;
    logic        den_next;

    // Strobes decode the next counter values so they register alongside the position they describe.
    always_comb begin
        pix_tick = NCLK;
        col_wrap = (Columna == COL_LAST);
        row_wrap = col_wrap && (Fila == ROW_LAST);
        col_next = col_wrap ? 11'd0 : Columna + 11'd1;
        row_next = Fila;
        if (row_wrap) begin
            row_next = 10'd0;
        end else if (col_wrap) begin
            row_next = Fila + 10'd1;
        end
        hd_next  = !(col_next < HS_END);
        vd_next  = !(row_next < VS_END);
        den_next = (col_next >= DEN_X0) && (col_next < DEN_X1) &&
                   (row_next >= DEN_Y0) && (row_next < DEN_Y1);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            NCLK      <= 1'b0;
            GREST     <= 1'b0;
            HD        <= 1'b0;
            VD        <= 1'b0;
            DEN       <= 1'b0;
            Columna   <= 11'd0;
            Fila      <= 10'd0;
            FRAME_END <= 1'b0;
        end else begin
            NCLK      <= ~NCLK;
            GREST     <= 1'b1;
            FRAME_END <= pix_tick && row_wrap;
            if (pix_tick) begin
                Columna <= col_next;
                Fila    <= row_next;
                HD      <= hd_next;
                VD      <= vd_next;
                DEN     <= den_next;
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: full-size panel, wide-sync override and a shrunken geometry
// that makes whole-frame behaviour reachable in a short run.
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    int   denCount;
    int   feCount;
    int   feEdge;

    logic        aNclk, aGrest, aHd, aVd, aDen, aFrameEnd;
    logic [10:0] aCol;
    logic [9:0]  aRow;
    logic        bNclk, bGrest, bHd, bVd, bDen, bFrameEnd;
    logic [10:0] bCol;
    logic [9:0]  bRow;
    logic        cNclk, cGrest, cHd, cVd, cDen, cFrameEnd;
    logic [10:0] cCol;
    logic [9:0]  cRow;

    always #5 clk = ~clk;

    lcd_timing_gen dutA (
        .CLK(clk), .RST_n(rstN), .NCLK(aNclk), .GREST(aGrest), .HD(aHd), .VD(aVd),
        .DEN(aDen), .Columna(aCol), .Fila(aRow), .FRAME_END(aFrameEnd)
    );

    lcd_timing_gen #(.HSYNC_W(48), .VSYNC_W(3)) dutB (
        .CLK(clk), .RST_n(rstN), .NCLK(bNclk), .GREST(bGrest), .HD(bHd), .VD(bVd),
        .DEN(bDen), .Columna(bCol), .Fila(bRow), .FRAME_END(bFrameEnd)
    );

    // 12 x 9 geometry: visible columns 4..9, visible rows 3..6, 108 ticks per frame.
    lcd_timing_gen #(
        .BACK_PORCH_X(4), .BACK_PORCH_Y(3), .FRONT_PORCH_X(2), .FRONT_PORCH_Y(2),
        .SCREEN_SIZE_X(6), .SCREEN_SIZE_Y(4), .HSYNC_W(1), .VSYNC_W(1)
    ) dutC (
        .CLK(clk), .RST_n(rstN), .NCLK(cNclk), .GREST(cGrest), .HD(cHd), .VD(cVd),
        .DEN(cDen), .Columna(cCol), .Fila(cRow), .FRAME_END(cFrameEnd)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal);
        rstN  = rstVal;
        edges = 0;
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic advanceTo(input int target);
        advance(target - edges);
    endtask

    initial begin
        rstN = 1'b0;
        advance(3);
        checkOutput("rst_nclk",  32'(aNclk), 0);
        checkOutput("rst_grest", 32'(aGrest), 0);
        checkOutput("rst_hd",    32'(aHd), 0);
        checkOutput("rst_vd",    32'(aVd), 0);
        checkOutput("rst_den",   32'(aDen), 0);
        checkOutput("rst_col",   32'(aCol), 0);
        checkOutput("rst_row",   32'(aRow), 0);
        checkOutput("rst_fe",    32'(aFrameEnd), 0);

        // Release on a falling edge; edge n below is the n-th CLK rise after release.
        applyStimulus(1'b1);
        advance(1);
        checkOutput("e1_nclk",  32'(aNclk), 1);
        checkOutput("e1_grest", 32'(aGrest), 1);
        checkOutput("e1_col",   32'(aCol), 0);
        checkOutput("e1_hd",    32'(aHd), 0);
        checkOutput("e1_fe",    32'(aFrameEnd), 0);
        advance(1);
        checkOutput("e2_nclk", 32'(aNclk), 0);
        checkOutput("e2_col",  32'(aCol), 1);
        checkOutput("e2_hd",   32'(aHd), 1);
        checkOutput("e2_vd",   32'(aVd), 0);
        checkOutput("e2_row",  32'(aRow), 0);
        checkOutput("e2_bhd",  32'(bHd), 0);
        advance(1);
        checkOutput("e3_nclk", 32'(aNclk), 1);
        checkOutput("e3_col",  32'(aCol), 1);

        advanceTo(94);
        checkOutput("b_col47", 32'(bCol), 47);
        checkOutput("b_hd47",  32'(bHd), 0);
        advanceTo(96);
        checkOutput("b_col48", 32'(bCol), 48);
        checkOutput("b_hd48",  32'(bHd), 1);
        checkOutput("b_vd0",   32'(bVd), 0);

        advanceTo(432);
        checkOutput("a_col216", 32'(aCol), 216);
        checkOutput("a_den_row0", 32'(aDen), 0);

        advanceTo(2110);
        checkOutput("a_col1055", 32'(aCol), 1055);
        checkOutput("a_row_l0",  32'(aRow), 0);
        checkOutput("a_hd1055",  32'(aHd), 1);
        advance(1);
        checkOutput("a_hd_2111", 32'(aHd), 1);
        advance(1);
        checkOutput("a_col_wrap", 32'(aCol), 0);
        checkOutput("a_row_l1",   32'(aRow), 1);
        checkOutput("a_hd_2112",  32'(aHd), 0);
        checkOutput("a_vd_row1",  32'(aVd), 1);
        checkOutput("a_fe_line",  32'(aFrameEnd), 0);
        advance(1);
        checkOutput("a_hd_2113", 32'(aHd), 0);
        advance(1);
        checkOutput("a_hd_2114", 32'(aHd), 1);
        checkOutput("a_col_2114", 32'(aCol), 1);

        advanceTo(4224);
        checkOutput("b_row2", 32'(bRow), 2);
        checkOutput("b_vd2",  32'(bVd), 0);
        checkOutput("b_hd_l2", 32'(bHd), 0);
        advanceTo(6336);
        checkOutput("b_row3", 32'(bRow), 3);
        checkOutput("b_vd3",  32'(bVd), 1);
        checkOutput("a_vd3",  32'(aVd), 1);

        applyStimulus(1'b0);
        advance(2);
        applyStimulus(1'b1);

        advanceTo(56);
        checkOutput("c_den_r2c4", 32'(cDen), 0);
        checkOutput("c_row_56",   32'(cRow), 2);
        advanceTo(78);
        checkOutput("c_den_r3c3", 32'(cDen), 0);
        checkOutput("c_col_78",   32'(cCol), 3);
        advanceTo(80);
        checkOutput("c_den_first", 32'(cDen), 1);
        checkOutput("c_col_80",    32'(cCol), 4);
        checkOutput("c_row_80",    32'(cRow), 3);
        advanceTo(162);
        checkOutput("c_den_last", 32'(cDen), 1);
        checkOutput("c_col_162",  32'(cCol), 9);
        checkOutput("c_row_162",  32'(cRow), 6);
        advanceTo(164);
        checkOutput("c_den_c10", 32'(cDen), 0);
        advanceTo(176);
        checkOutput("c_den_r7", 32'(cDen), 0);
        checkOutput("c_row_176", 32'(cRow), 7);

        advanceTo(214);
        checkOutput("c_col_last", 32'(cCol), 11);
        checkOutput("c_row_last", 32'(cRow), 8);
        checkOutput("c_fe_214",   32'(cFrameEnd), 0);
        advanceTo(216);
        checkOutput("c_col_fw", 32'(cCol), 0);
        checkOutput("c_row_fw", 32'(cRow), 0);
        checkOutput("c_vd_fw",  32'(cVd), 0);
        checkOutput("c_hd_fw",  32'(cHd), 0);
        checkOutput("c_fe_216", 32'(cFrameEnd), 1);
        advance(1);
        checkOutput("c_fe_217", 32'(cFrameEnd), 0);

        denCount = 0;
        feCount  = 0;
        feEdge   = -1;
        for (int i = 0; i < 215; i++) begin
            advance(1);
            if ((edges % 2 == 0) && cDen) denCount++;
            if (cFrameEnd) begin
                feCount++;
                feEdge = edges;
            end
        end
        checkOutput("c_den_count", 32'(denCount), 24);
        checkOutput("c_fe_count",  32'(feCount), 1);
        checkOutput("c_fe_edge",   32'(feEdge), 432);

        advanceTo(567);
        checkOutput("c_mid_den",  32'(cDen), 1);
        checkOutput("c_mid_col",  32'(cCol), 7);
        checkOutput("c_mid_row",  32'(cRow), 5);
        checkOutput("c_mid_nclk", 32'(cNclk), 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("c_ar_nclk",  32'(cNclk), 0);
        checkOutput("c_ar_grest", 32'(cGrest), 0);
        checkOutput("c_ar_den",   32'(cDen), 0);
        checkOutput("c_ar_col",   32'(cCol), 0);
        checkOutput("c_ar_row",   32'(cRow), 0);
        checkOutput("c_ar_hd",    32'(cHd), 0);
        checkOutput("c_ar_vd",    32'(cVd), 0);
        checkOutput("a_ar_col",   32'(aCol), 0);
        @(negedge clk);
        applyStimulus(1'b1);
        advance(1);
        checkOutput("c_re1_nclk",  32'(cNclk), 1);
        checkOutput("c_re1_grest", 32'(cGrest), 1);
        checkOutput("c_re1_col",   32'(cCol), 0);
        checkOutput("c_re1_hd",    32'(cHd), 0);
        checkOutput("c_re1_fe",    32'(cFrameEnd), 0);
        advance(1);
        checkOutput("c_re2_nclk", 32'(cNclk), 0);
        checkOutput("c_re2_col",  32'(cCol), 1);
        checkOutput("c_re2_hd",   32'(cHd), 1);
        checkOutput("c_re2_vd",   32'(cVd), 0);
        advance(1);
        checkOutput("c_re3_nclk", 32'(cNclk), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
